// File: rtl/display_pkg.sv
// Shared definitions for the range-hood display arbiter: source indices,
// FSM state encoding and the per-source display payload.
package display_pkg;

  localparam int unsigned DISP_W = 8;

  localparam int unsigned SRC_TIME    = 0;
  localparam int unsigned SRC_GESTURE = 1;
  localparam int unsigned SRC_SMOKER  = 2;
  localparam int unsigned SRC_CLEAN   = 3;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [DISP_W-1:0] digit1;
    logic [DISP_W-1:0] digit2;
    logic [DISP_W-1:0] tube_sel;
  } disp_t;

endpackage

// File: rtl/disp_prio_enc.sv
// Highest-set-index encoder; bit 0 is always treated as requesting so the
// clock source is the fallback winner.
module disp_prio_enc #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] winner_c
);

  always_comb begin
    winner_c = '0;
    for (int i = 1; i < int'(N_REQ); i++) begin
      if (req[i]) winner_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares the seven-segment display between prioritised sources with a
// minimum hold time, a blanking gap on every change and forced blank when off.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MIN_HOLD_CYC = 50_000_000,
  parameter int unsigned BLANK_CYC    = 1_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      machine_state,
  input  logic [N_REQ-1:0]          req,
  input  logic [DISP_W*N_REQ-1:0]   digit1_in,
  input  logic [DISP_W*N_REQ-1:0]   digit2_in,
  input  logic [DISP_W*N_REQ-1:0]   tube_sel_in,
  output logic [DISP_W-1:0]         digit1,
  output logic [DISP_W-1:0]         digit2,
  output logic [DISP_W-1:0]         tube_sel,
  output logic [N_REQ-1:0]          grant,
  output logic                      switch_pulse
);

  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HOLD_W  = $clog2(MIN_HOLD_CYC + 1);
  localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD_CYC);
  localparam logic [BLANK_W-1:0] BLANK_END = BLANK_W'(BLANK_CYC - 1);

  disp_state_e        state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [IDX_W-1:0]   tgt_q, tgt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  disp_t              disp_q, disp_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               switch_q, switch_d;
  logic [IDX_W-1:0]   winner_c;

  disp_prio_enc #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req      (req),
    .winner_c (winner_c)
  );

  // Next-state, counters and the registered display/grant payload.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    hold_d   = hold_q;
    blank_d  = blank_q;
    disp_d   = '0;
    grant_d  = '0;
    switch_d = 1'b0;

    if (!machine_state) begin
      state_d = OFF;
      hold_d  = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          tgt_d   = winner_c;
          blank_d = '0;
          state_d = BLANK;
        end
        BLANK: begin
          if (winner_c != tgt_q) begin
            tgt_d   = winner_c;
            blank_d = '0;
          end else if (blank_q == BLANK_END) begin
            cur_d   = tgt_q;
            hold_d  = '0;
            blank_d = '0;
            state_d = SHOW;
          end else begin
            blank_d = blank_q + BLANK_W'(1);
          end
        end
        SHOW: begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
          // Higher priority preempts at once; a lower one waits out the hold.
          if ((winner_c > cur_q) || ((winner_c < cur_q) && (hold_q == HOLD_MAX))) begin
            tgt_d   = winner_c;
            blank_d = '0;
            state_d = BLANK;
          end
        end
        default: state_d = OFF;
      endcase
    end

    if (state_d == SHOW) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (cur_d == IDX_W'(i)) begin
          disp_d.digit1   = digit1_in[i*DISP_W +: DISP_W];
          disp_d.digit2   = digit2_in[i*DISP_W +: DISP_W];
          disp_d.tube_sel = tube_sel_in[i*DISP_W +: DISP_W];
          grant_d[i]      = 1'b1;
        end
      end
    end

    switch_d = (state_d == BLANK) && (state_q != BLANK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= OFF;
      cur_q    <= '0;
      tgt_q    <= '0;
      hold_q   <= '0;
      blank_q  <= '0;
      disp_q   <= '0;
      grant_q  <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      hold_q   <= hold_d;
      blank_q  <= blank_d;
      disp_q   <= disp_d;
      grant_q  <= grant_d;
      switch_q <= switch_d;
    end
  end

  assign digit1       = disp_q.digit1;
  assign digit2       = disp_q.digit2;
  assign tube_sel     = disp_q.tube_sel;
  assign grant        = grant_q;
  assign switch_pulse = switch_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed-vector bench for display_arbiter with short hold/blank parameters.
module tb_display_arbiter;

  localparam int unsigned N_REQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                machine_state;
  logic [N_REQ-1:0]    req;
  logic [8*N_REQ-1:0]  digit1_in, digit2_in, tube_sel_in;
  logic [7:0]          digit1, digit2, tube_sel;
  logic [N_REQ-1:0]    grant;
  logic                switch_pulse;

  int n_vec = 0;
  int n_err = 0;

  display_arbiter #(
    .N_REQ        (N_REQ),
    .MIN_HOLD_CYC (8),
    .BLANK_CYC    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .machine_state (machine_state),
    .req           (req),
    .digit1_in     (digit1_in),
    .digit2_in     (digit2_in),
    .tube_sel_in   (tube_sel_in),
    .digit1        (digit1),
    .digit2        (digit2),
    .tube_sel      (tube_sel),
    .grant         (grant),
    .switch_pulse  (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_show(input string tag, input logic [3:0] g, input logic [7:0] d1);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_digit1"}, 32'(digit1), 32'(d1));
  endtask

  task automatic check_blank(input string tag, input logic sp);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_digit1"}, 32'(digit1), 32'h0);
    check({tag, "_tube"}, 32'(tube_sel), 32'h0);
    check({tag, "_pulse"}, 32'(switch_pulse), 32'(sp));
  endtask

  initial begin
    rst = 1'b0;
    machine_state = 1'b0;
    req = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      digit1_in[i*8 +: 8]   = 8'h10 + 8'(i);
      digit2_in[i*8 +: 8]   = 8'h20 + 8'(i);
      tube_sel_in[i*8 +: 8] = 8'h30 + 8'(i);
    end

    #2;
    check_blank("reset", 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_blank("off_idle", 1'b0);

    // Power on: two blank cycles, then the clock source.
    machine_state = 1'b1;
    tick(); check_blank("on_b0", 1'b1);
    tick(); check_blank("on_b1", 1'b0);
    tick(); check_show("on_src0", 4'b0001, 8'h10);
    check("on_digit2", 32'(digit2), 32'h20);
    check("on_tube", 32'(tube_sel), 32'h30);

    // Source data passes straight through while shown.
    digit1_in[7:0] = 8'h55;
    tick(); check_show("pass", 4'b0001, 8'h55);
    digit1_in[7:0] = 8'h10;
    tick(); check_show("pass_back", 4'b0001, 8'h10);

    // Preemption by the clean source.
    req = 4'b1000;
    tick(); check_blank("pre_b0", 1'b1);
    tick(); check_blank("pre_b1", 1'b0);
    tick(); check_show("pre_src3", 4'b1000, 8'h13);

    // Shown 3 cycles, drop to smoker: held until hold count reaches 8.
    tick(); tick();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick(); check_show($sformatf("hold%0d", i), 4'b1000, 8'h13);
    end
    tick(); check_blank("ret_b0", 1'b1);
    tick(); check_blank("ret_b1", 1'b0);
    tick(); check_show("ret_src2", 4'b0100, 8'h12);

    // Head toward gesture, then retarget to smoker mid-gap.
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick(); check_show($sformatf("hold2_%0d", i), 4'b0100, 8'h12);
    end
    tick(); check_blank("rt_b0", 1'b1);
    req = 4'b0110;
    tick(); check_blank("rt_retarget", 1'b0);
    tick(); check_blank("rt_restart", 1'b0);
    tick(); check_show("rt_src2", 4'b0100, 8'h12);

    // Machine off mid-show.
    machine_state = 1'b0;
    tick(); check_blank("off_show", 1'b0);
    check("off_digit2", 32'(digit2), 32'h0);
    tick(); check_blank("off_stay", 1'b0);

    // Simultaneous gesture and smoker requests from src0.
    req = 4'b0000;
    machine_state = 1'b1;
    tick(); tick(); tick(); check_show("sim_src0", 4'b0001, 8'h10);
    req = 4'b0110;
    tick(); check_blank("sim_b0", 1'b1);
    tick(); check_blank("sim_b1", 1'b0);
    tick(); check_show("sim_src2", 4'b0100, 8'h12);
    tick(); check("sim_one_pulse", 32'(switch_pulse), 32'h0);
    check_show("sim_stay", 4'b0100, 8'h12);

    // Machine fall with a new request: off wins.
    machine_state = 1'b0;
    req = 4'b1000;
    tick(); check_blank("offwins", 1'b0);

    // Asynchronous reset clears the pulse mid-blank without a clock edge.
    machine_state = 1'b1;
    tick(); check_blank("ar_b0", 1'b1);
    rst = 1'b0;
    #1; check("async_rst_pulse", 32'(switch_pulse), 32'h0);
    tick();
    rst = 1'b1;
    tick(); tick();
    tick(); check_show("ar_src3", 4'b1000, 8'h13);
    #1; rst = 1'b0;
    #1; check("async_rst_digit1", 32'(digit1), 32'h0);
    check("async_rst_grant", 32'(grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Sequential arbiter that shares the single 8-digit seven-segment display (digit1/digit2/tube_sel) between the display sources of the range-hood controller: current-time clock, gesture-time readout, smoker countdown/accumulated-time readout and self-clean countdown. It sits between those source modules and the board pins, replacing the mode-indexed display mux. It enforces fixed priority, a minimum on-screen hold time, a blanking gap on every source change, and a blank display while the machine is off.

## Interface
Parameters:
- N_REQ, 4, number of sources; index = priority, higher index wins
- MIN_HOLD_CYC, 50_000_000, minimum cycles a granted source stays shown before a lower-priority switch
- BLANK_CYC, 1_000, cycles of blank display inserted on every source change (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- machine_state  in  1  1 = machine on; 0 forces blank display
- req  in  N_REQ  level requests; bit 0 (time) is treated as always asserted
- digit1_in  in  8*N_REQ  packed segment data, source i at [8i+7:8i]
- digit2_in  in  8*N_REQ  packed segment data
- tube_sel_in  in  8*N_REQ  packed digit enables
- digit1  out  8  registered segments to display
- digit2  out  8  registered segments to display
- tube_sel  out  8  registered digit enables
- grant  out  N_REQ  one-hot source currently shown; 0 when OFF or BLANK
- switch_pulse  out  1  one-cycle pulse on entry to BLANK

## Operation
- States: OFF, BLANK, SHOW. Registers: cur (shown source index), tgt (pending index), hold_cnt, blank_cnt.
- winner = highest set index of (req | 1); computed combinationally each cycle.
- OFF: all outputs 0. On machine_state=1: tgt←winner, → BLANK.
- BLANK: outputs 0, grant 0, blank_cnt counts up. If winner ≠ tgt: tgt←winner, blank_cnt←0 (retarget restarts gap). When blank_cnt = BLANK_CYC-1: cur←tgt, hold_cnt←0, → SHOW.
- SHOW: outputs ← input slice cur; grant = 1<<cur; hold_cnt increments, saturating at MIN_HOLD_CYC.
  - winner > cur: preempt immediately → BLANK, tgt←winner.
  - winner < cur (cur dropped request): stay until hold_cnt = MIN_HOLD_CYC, then → BLANK, tgt←winner.
  - winner = cur: stay.
- machine_state=0 in any state: → OFF next edge, counters cleared.
- hold_cnt width $clog2(MIN_HOLD_CYC+1), blank_cnt width $clog2(BLANK_CYC+1); no wrap.
- Reset: state OFF, cur=tgt=0, counters 0, all outputs 0, switch_pulse 0.

## Timing
- SHOW data path: input slice to output register, 1-cycle latency; source data changes pass through within SHOW without blanking.
- Preemption: request rising at edge k → state BLANK and switch_pulse=1 at k+1 → new source visible at k+1+BLANK_CYC.
- Lower-priority return: switch no earlier than MIN_HOLD_CYC cycles after entry to SHOW.
- machine_state fall: outputs 0 one edge later regardless of state.
- Simultaneous requests: highest index wins; simultaneous machine_state fall and request: OFF wins.

## Structure
- Shared package display_pkg: SRC_TIME=0, SRC_GESTURE=1, SRC_SMOKER=2, SRC_CLEAN=3, state enum {OFF, BLANK, SHOW}, DISP_W=8.
- One sub-module: disp_prio_enc (N_REQ-bit highest-set-index encoder, bit 0 forced).
- Source-to-pin mux and FSM in display_arbiter itself.

## Test plan
(MIN_HOLD_CYC=8, BLANK_CYC=2, each digit1_in slice = 8'h10+i.)
- Reset, machine_state=1, req=0 → 2 blank cycles, then grant=0001, digit1=8'h10.
- In SHOW src0, assert req[3] → next cycle switch_pulse=1, outputs 0 for 2 cycles, then grant=1000, digit1=8'h13.
- Src3 shown 3 cycles, drop req[3] with req[2]=1 → stays src3 until hold_cnt=8, then BLANK, then grant=0100.
- During BLANK toward src1, assert req[2] → tgt retargets, blank count restarts, src2 shown 2 cycles after retarget.
- machine_state→0 mid-SHOW → next cycle digit1/digit2/tube_sel/grant=0; rst low mid-BLANK → outputs 0 immediately, no clock needed.
- req[1] and req[2] rise same cycle → only src2 granted, one switch_pulse.
